// File: rtl/prescaler_ctrl.sv
// ---------------------------------------------------------------------------
// prescaler_ctrl
//
// Runtime-programmable clock prescaler. Produces a one-cycle `tick` clock
// enable every `div_active` cycles and a 50%-duty `Clk_out` square wave that
// toggles on every tick. Divisor and mode are loaded through a valid/ready
// configuration port. From IDLE a configuration applies immediately; while
// running it is parked in a one-entry pending slot and applied at a period
// boundary, so the period in progress always completes at the old divisor.
//
// Optional feature macro: PRESCALER_CTRL_TICKCNT_EN
//   defined   -> adds 16-bit output `tick_count` (saturating tick counter,
//                cleared on Rst and on every applied configuration)
//   undefined -> port and counter absent, all other behaviour identical
//
// Ports
//   Clk_in     in   system clock
//   Rst        in   synchronous, active-high reset
//   cfg_valid  in   configuration request
//   cfg_ready  out  pending slot free (accept when cfg_valid && cfg_ready)
//   cfg_div    in   requested divisor, cycles per tick (>= 2)
//   cfg_mode   in   00 STOP, 01 RUN, 10 BURST, 11 reserved (rejected)
//   cfg_burst  in   tick count for BURST (non-zero)
//   tick       out  one-cycle pulse per period
//   Clk_out    out  toggles on every tick
//   busy       out  state is not IDLE (registered, one edge behind state)
//   done       out  one-cycle pulse when a burst completes
//   err        out  one-cycle pulse when a configuration is rejected
//   tick_count out  (macro only) saturating count of ticks
// ---------------------------------------------------------------------------
module prescaler_ctrl #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 12500
) (
    input  logic             Clk_in,
    input  logic             Rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [1:0]       cfg_mode,
    input  logic [7:0]       cfg_burst,
    output logic             tick,
    output logic             Clk_out,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef PRESCALER_CTRL_TICKCNT_EN
    ,
    output logic [15:0]      tick_count
`endif
);

    localparam logic [1:0] MODE_STOP  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    localparam logic [CNT_W-1:0] DIV_RESET = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DIV_MIN   = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] div_active_reg;
    logic [7:0]       remain_reg;

    logic             pend_valid_reg;
    logic [CNT_W-1:0] pend_div_reg;
    logic [1:0]       pend_mode_reg;
    logic [7:0]       pend_burst_reg;

    logic             tick_reg;
    logic             clk_out_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;

    // -----------------------------------------------------------------------
    // Request qualification
    // -----------------------------------------------------------------------
    logic accept;
    logic cfg_bad;
    logic accept_ok;
    logic accept_bad;
    logic running;
    logic wrap;
    logic pend_wrap_ok;

    assign accept     = cfg_valid && !pend_valid_reg;
    assign cfg_bad    = (cfg_div < DIV_MIN) ||
                        (cfg_mode == MODE_RSVD) ||
                        ((cfg_mode == MODE_BURST) && (cfg_burst == 8'd0));
    assign accept_ok  = accept && !cfg_bad;
    assign accept_bad = accept && cfg_bad;

    assign running = (state_reg != ST_IDLE);
    assign wrap    = running && (count_reg == (div_active_reg - CNT_ONE));

    // A pending STOP from RUN waits for the wrap that drives Clk_out low so
    // the output always parks at 0. From BURST any pending config (STOP
    // included) is taken at the very next wrap and aborts the burst.
    assign pend_wrap_ok = wrap &&
                          ((state_reg == ST_BURST) ||
                           (pend_mode_reg != MODE_STOP) ||
                           clk_out_reg);

    // -----------------------------------------------------------------------
    // Configuration to apply on this edge, if any.
    // The pending slot has priority; it can also be non-empty in IDLE when a
    // request was parked on the same edge that a burst finished, in which
    // case it is applied right away.
    // -----------------------------------------------------------------------
    logic             apply_now;
    logic             apply_from_pend;
    logic [CNT_W-1:0] apply_div;
    logic [1:0]       apply_mode;
    logic [7:0]       apply_burst;

    always_comb begin
        apply_now       = 1'b0;
        apply_from_pend = 1'b0;
        apply_div       = pend_div_reg;
        apply_mode      = pend_mode_reg;
        apply_burst     = pend_burst_reg;
        if (pend_valid_reg && ((state_reg == ST_IDLE) || pend_wrap_ok)) begin
            apply_now       = 1'b1;
            apply_from_pend = 1'b1;
        end else if ((state_reg == ST_IDLE) && accept_ok) begin
            apply_now   = 1'b1;
            apply_div   = cfg_div;
            apply_mode  = cfg_mode;
            apply_burst = cfg_burst;
        end
    end

    function automatic state_t mode_state(input logic [1:0] mode);
        case (mode)
            MODE_RUN:   mode_state = ST_RUN;
            MODE_BURST: mode_state = ST_BURST;
            default:    mode_state = ST_IDLE;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Controller
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk_in) begin
        if (Rst) begin
            state_reg      <= ST_IDLE;
            count_reg      <= CNT_ZERO;
            div_active_reg <= DIV_RESET;
            remain_reg     <= 8'd0;
            pend_valid_reg <= 1'b0;
            pend_div_reg   <= CNT_ZERO;
            pend_mode_reg  <= MODE_STOP;
            pend_burst_reg <= 8'd0;
            tick_reg       <= 1'b0;
            clk_out_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            tick_reg <= 1'b0;
            done_reg <= 1'b0;
            err_reg  <= accept_bad;
            busy_reg <= running;

            // Pending slot: a good request accepted while running is parked,
            // even on a wrap edge; it is consumed by a later apply. The two
            // cases are exclusive because accepting requires an empty slot.
            if (accept_ok && running) begin
                pend_valid_reg <= 1'b1;
                pend_div_reg   <= cfg_div;
                pend_mode_reg  <= cfg_mode;
                pend_burst_reg <= cfg_burst;
            end else if (apply_from_pend) begin
                pend_valid_reg <= 1'b0;
            end

            if (!running) begin
                count_reg <= CNT_ZERO;
                if (apply_now) begin
                    div_active_reg <= apply_div;
                    remain_reg     <= apply_burst;
                    state_reg      <= mode_state(apply_mode);
                end
            end else if (wrap) begin
                count_reg   <= CNT_ZERO;
                tick_reg    <= 1'b1;
                clk_out_reg <= ~clk_out_reg;

                if (state_reg == ST_BURST) begin
                    remain_reg <= remain_reg - 8'd1;
                    // Last tick of the burst; an aborting STOP suppresses done.
                    if ((remain_reg == 8'd1) &&
                        !(apply_now && (apply_mode == MODE_STOP))) begin
                        done_reg <= 1'b1;
                    end
                    if ((remain_reg == 8'd1) && !apply_now) begin
                        state_reg <= ST_IDLE;
                    end
                end

                // Applied after the tick of the old period; overrides the
                // burst bookkeeping above.
                if (apply_now) begin
                    div_active_reg <= apply_div;
                    remain_reg     <= apply_burst;
                    state_reg      <= mode_state(apply_mode);
                end
            end else begin
                count_reg <= count_reg + CNT_ONE;
            end
        end
    end

`ifdef PRESCALER_CTRL_TICKCNT_EN
    // Counts ticks since the last applied configuration. When a pending
    // config is applied on a wrap, the clear wins over that edge's tick.
    logic [15:0] tick_count_reg;

    always_ff @(posedge Clk_in) begin
        if (Rst) begin
            tick_count_reg <= 16'd0;
        end else if (apply_now) begin
            tick_count_reg <= 16'd0;
        end else if (wrap && (tick_count_reg != 16'hFFFF)) begin
            tick_count_reg <= tick_count_reg + 16'd1;
        end
    end

    assign tick_count = tick_count_reg;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cfg_ready = !pend_valid_reg;
    assign tick      = tick_reg;
    assign Clk_out   = clk_out_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule
